// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg -- shared encodings for the execute-stage multiply/divide unit.
// Holds the 3-bit MDU operation codes (RISC-V M-extension funct3 order), the
// MDU control FSM state encoding and small decode helpers used by ex_mdu and
// ex_mdu_div.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Bit 2 of the op code separates the divide group from the multiply group.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Within the divide group: bit 0 clear means signed, bit 1 set means remainder.
  function automatic logic op_div_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_div_rem(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_mdu_div.sv
// ex_mdu_div -- iterative restoring divider for the MDU.
// Works on operand magnitudes, retires RADIX_LOG2 quotient bits per cycle and
// spends one extra cycle on the sign fix-up. Divide-by-zero and signed
// overflow are detected at start and answered without iterating.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          load operands and begin (one-cycle pulse)
//   flush_i          abandon the operation in flight
//   op_a_i, op_b_i   dividend / divisor, sampled on start_i
//   signed_i         signed operation (DIV/REM)
//   rem_i            return remainder instead of quotient
//   done_o           result_o is written on the next rising edge
//   result_o         registered quotient or remainder
module ex_mdu_div
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            signed_i,
  input  logic            rem_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int ITER = (XLEN + RADIX_LOG2 - 1) / RADIX_LOG2;
  localparam int QW   = ITER * RADIX_LOG2;
  localparam int CW   = $clog2(ITER + 1);

  logic            active_q, special_q, q_neg_q, r_neg_q, rem_q;
  logic [QW-1:0]   quo_q;
  logic [XLEN:0]   rem_acc_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;

  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [XLEN:0]   step_r;
  logic [QW-1:0]   step_q;

  assign a_neg    = signed_i & op_a_i[XLEN-1];
  assign b_neg    = signed_i & op_b_i[XLEN-1];
  assign a_mag    = a_neg ? -op_a_i : op_a_i;
  assign b_mag    = b_neg ? -op_b_i : op_b_i;
  assign div_zero = (op_b_i == '0);
  assign div_ovf  = signed_i & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);

  // RADIX_LOG2 restoring steps: shift the next dividend bit into the partial
  // remainder and subtract the divisor whenever it fits.
  always_comb begin
    step_r = rem_acc_q;
    step_q = quo_q;
    for (int i = 0; i < RADIX_LOG2; i++) begin
      step_r = {step_r[XLEN-1:0], step_q[QW-1]};
      step_q = {step_q[QW-2:0], 1'b0};
      if (step_r >= dvs_q) begin
        step_r    = step_r - dvs_q;
        step_q[0] = 1'b1;
      end
    end
  end

  assign quo_fix = q_neg_q ? -quo_q[XLEN-1:0] : quo_q[XLEN-1:0];
  assign rem_fix = r_neg_q ? -rem_acc_q[XLEN-1:0] : rem_acc_q[XLEN-1:0];

  // Special cases finish one cycle after start; otherwise the fix-up cycle
  // follows the last iteration.
  assign done_o   = active_q & (special_q | (cnt_q == '0));
  assign result_o = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      special_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_q     <= 1'b0;
      quo_q     <= '0;
      rem_acc_q <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (flush_i) begin
      active_q <= 1'b0;
    end else if (start_i) begin
      active_q  <= 1'b1;
      special_q <= div_zero | div_ovf;
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
      rem_q     <= rem_i;
      quo_q     <= QW'(a_mag);
      rem_acc_q <= '0;
      dvs_q     <= {1'b0, b_mag};
      cnt_q     <= CW'(ITER);
      if (div_zero) begin
        result_q <= rem_i ? op_a_i : '1;
      end else if (div_ovf) begin
        result_q <= rem_i ? '0 : op_a_i;
      end
    end else if (active_q) begin
      if (done_o) begin
        active_q <= 1'b0;
        if (!special_q) begin
          result_q <= rem_q ? rem_fix : quo_fix;
        end
      end else begin
        quo_q     <= step_q;
        rem_acc_q <= step_r;
        cnt_q     <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu -- execute-stage multiply/divide unit (RV32M style).
// One operation at a time: IDLE accepts, MUL waits a fixed latency, DIV runs
// the iterative divider in ex_mdu_div, DONE holds the result for the mem stage.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge,
// and ready may depend on state but never on the partner's valid.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   request handshake from the id/ex register
//   req_op_i                    mdu_op_e operation code
//   req_op_a_i / req_op_b_i     rs1 / rs2 operands
//   req_waddr_i                 destination register index
//   resp_valid_o / resp_ready_i result handshake to the mem stage
//   resp_data_o / resp_waddr_o  result and captured destination index
//   busy_o                      front-end stall request
//   flush_i                     abort the operation in flight
//   dbg_state_o                 current FSM state (mdu_state_e)
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_op_a_i,
  input  logic [XLEN-1:0] req_op_b_i,
  input  logic [4:0]      req_waddr_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic [4:0]      resp_waddr_o,
  output logic            busy_o,
  input  logic            flush_i,
  output logic [1:0]      dbg_state_o
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [4:0]        waddr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] product_q;

  logic              accept, div_done, a_sgn, b_sgn;
  logic [XLEN-1:0]   div_result;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_full;

  // flush_i wins over a request arriving in the same cycle.
  assign accept = req_valid_i & (state_q == ST_IDLE) & ~flush_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = op_is_div(req_op_i) ? ST_DIV : ST_MUL;
      ST_MUL:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: if (resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  // A flushed DONE result is discarded, so valid is withheld in that cycle.
  always_comb begin
    req_ready_o  = (state_q == ST_IDLE);
    resp_valid_o = (state_q == ST_DONE) & ~flush_i;
    busy_o       = (state_q != ST_IDLE) & ~((state_q == ST_DONE) & resp_ready_i);
    dbg_state_o  = state_q;
  end

  // ---------------- request capture and multiply ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      op_q    <= req_op_i;
      a_q     <= req_op_a_i;
      b_q     <= req_op_b_i;
      waddr_q <= req_waddr_i;
      cnt_q   <= CNT_LOAD;
    end else if (state_q == ST_MUL) begin
      product_q <= mul_full;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Sign-extending both operands to 2*XLEN makes the modulo-2^(2*XLEN)
  // product correct for every signedness combination.
  assign a_sgn    = (op_q == OP_MULH) | (op_q == OP_MULHSU);
  assign b_sgn    = (op_q == OP_MULH);
  assign mul_a    = {{XLEN{a_q[XLEN-1] & a_sgn}}, a_q};
  assign mul_b    = {{XLEN{b_q[XLEN-1] & b_sgn}}, b_q};
  assign mul_full = mul_a * mul_b;

  ex_mdu_div #(
    .XLEN       (XLEN),
    .RADIX_LOG2 (RADIX_LOG2)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept & op_is_div(req_op_i)),
    .flush_i  (flush_i),
    .op_a_i   (req_op_a_i),
    .op_b_i   (req_op_b_i),
    .signed_i (op_div_signed(req_op_i)),
    .rem_i    (op_div_rem(req_op_i)),
    .done_o   (div_done),
    .result_o (div_result)
  );

  always_comb begin
    if (op_is_div(op_q))     resp_data_o = div_result;
    else if (op_q == OP_MUL) resp_data_o = product_q[XLEN-1:0];
    else                     resp_data_o = product_q[2*XLEN-1:XLEN];
  end

  assign resp_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 16 + 5 + XLEN;  // {valid cycle, waddr, data}

  logic            clk, rst_n;
  logic            req_valid_i, req_ready_o;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] req_op_a_i, req_op_b_i;
  logic [4:0]      req_waddr_i;
  logic            resp_valid_o, resp_ready_i;
  logic [XLEN-1:0] resp_data_o;
  logic [4:0]      resp_waddr_o;
  logic            busy_o, flush_i;
  logic [1:0]      dbg_state_o;

  ex_mdu #(.XLEN(XLEN), .MUL_CYCLES(2), .RADIX_LOG2(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_op_a_i   (req_op_a_i),
    .req_op_b_i   (req_op_b_i),
    .req_waddr_i  (req_waddr_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_waddr_o (resp_waddr_o),
    .busy_o       (busy_o),
    .flush_i      (flush_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rise of resp_valid, payload on each handshake.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
        else                   check("resp_latency", 64'(cyc[15:0]), 64'(exp_q[0][W-1:W-16]));
      end
      if (resp_valid_o && resp_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_data", 64'(resp_data_o), 64'(e[XLEN-1:0]));
        check("resp_waddr", 64'(resp_waddr_o), 64'(e[XLEN+4:XLEN]));
      end
      prev_valid = resp_valid_o;
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] wa, input logic [XLEN-1:0] exp_data, input int lat,
                       input bit track);
    int t = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_op_a_i  = a;
    req_op_b_i  = b;
    req_waddr_i = wa;
    while (!req_ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      req_valid_i = 1'b0;
      return;
    end
    if (track) exp_q.push_back({16'(cyc + 1 + lat), wa, exp_data});
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    check({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int t;
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_op_a_i = '0; req_op_b_i = '0;
    req_waddr_i = '0; resp_ready_i = 1'b1; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_resp_data", 64'(resp_data_o), 64'd0);
    check("reset_resp_waddr", 64'(resp_waddr_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply group, latency 2.
    issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 2, 1);
    issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 2, 1);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 2, 1);
    issue(OP_MULHSU, 32'd2,        32'hFFFFFFFF, 5'd4,  32'h00000001, 2, 1);
    issue(OP_MULH,   32'hFFFFFFF9, 32'd3,        5'd5,  32'hFFFFFFFF, 2, 1);
    issue(OP_MULH,   32'h40000000, 32'd4,        5'd6,  32'h00000001, 2, 1);
    issue(OP_MUL,    32'h12345678, 32'h10,       5'd7,  32'h23456780, 2, 1);
    // Divide group, latency 33 (32 iterations + fix-up).
    issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33, 1);
    issue(OP_REM,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33, 1);
    issue(OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33, 1);
    issue(OP_REM,    32'd7,        32'hFFFFFFFE, 5'd11, 32'h00000001, 33, 1);
    issue(OP_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       33, 1);
    issue(OP_REMU,   32'd100,      32'd7,        5'd13, 32'd2,        33, 1);
    issue(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        33, 1);
    issue(OP_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 33, 1);
    // Fast path: divide by zero and signed overflow, latency 1.
    issue(OP_DIVU,   32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1, 1);
    issue(OP_REMU,   32'd5,        32'd0,        5'd17, 32'd5,        1, 1);
    issue(OP_REM,    32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFB, 1, 1);
    issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1, 1);
    issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1, 1);
    drain();

    // flush_i beats req_valid_i in IDLE: nothing is accepted.
    req_valid_i = 1'b1; req_op_i = OP_MUL; req_op_a_i = 32'd1; req_op_b_i = 32'd1; flush_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("flush_idle");
    @(posedge clk); #1;

    // Flush a DIV at cycle 10 after accept: no response, back to IDLE.
    issue(OP_DIV, 32'd100, 32'd3, 5'd21, 32'd0, 0, 0);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("flush_div");
    seen = 0;
    repeat (40) begin @(negedge clk); if (resp_valid_o) seen++; end
    check("flush_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(OP_MUL, 32'd9, 32'd9, 5'd22, 32'd81, 2, 1);
    drain();

    // Backpressure: result held stable for 5 cycles, then handshake.
    resp_ready_i = 1'b0;
    issue(OP_MUL, 32'd6, 32'd7, 5'd9, 32'd42, 2, 1);
    t = 0;
    @(negedge clk);
    while (!resp_valid_o && t < 50) begin @(negedge clk); t++; end
    check("bp_valid_seen", 64'(resp_valid_o), 64'd1);
    repeat (5) begin
      check("bp_hold_data", 64'(resp_data_o), 64'd42);
      check("bp_hold_waddr", 64'(resp_waddr_o), 64'd9);
      check("bp_hold_busy", 64'(busy_o), 64'd1);
      check("bp_hold_valid", 64'(resp_valid_o), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_busy_on_ready", 64'(busy_o), 64'd0);
    check("bp_ready_in_done", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1;
    check_idle_outputs("bp_after_hs");
    drain();

    // Reset in the middle of a DIV: abandoned, outputs back to reset values.
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd23, 32'd0, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    check("reset_mid_data", 64'(resp_data_o), 64'd0);
    check("reset_mid_waddr", 64'(resp_waddr_o), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (resp_valid_o) seen++; end
    check("reset_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd24, 32'd100, 33, 1);
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter MUL_CYCLES, default 2 (min 1): fixed multiply latency in cycles from accept to resp_valid.
REQ-003 Parameter RADIX_LOG2, default 1 (1 or 2): divider quotient bits retired per cycle.
REQ-004 The block uses one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid_i  in  1  request present from the id/ex register.
REQ-008 req_ready_o  out  1  block can accept a request.
REQ-009 req_op_i  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-010 req_op_a_i / req_op_b_i  in  XLEN  rs1 / rs2 operands.
REQ-011 req_waddr_i  in  5  destination register index.
REQ-012 resp_valid_o  out  1  result available.
REQ-013 resp_ready_i  in  1  mem stage accepts the result.
REQ-014 resp_data_o  out  XLEN  result; resp_waddr_o  out  5  captured destination index.
REQ-015 busy_o  out  1  to flow control: stall front end.
REQ-016 flush_i  in  1  abort the in-flight operation.

Function
REQ-017 States: IDLE, MUL, DIV, DONE; req_ready_o=1 only in IDLE.
REQ-018 Accept on req_valid_i & req_ready_o: latch op, operands, waddr; MUL ops go to MUL, DIV/REM ops to DIV.
REQ-019 MUL: a down-counter loads MUL_CYCLES-1; at zero go to DONE, so resp_valid_o rises exactly MUL_CYCLES cycles after accept.
REQ-020 MUL returns the low XLEN bits of the 2*XLEN product; MULH is signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, each returning the high XLEN bits.
REQ-021 DIV: restoring divide on magnitudes, RADIX_LOG2 bits per cycle; resp_valid_o rises ceil(XLEN/RADIX_LOG2)+1 cycles after accept, with the +1 for the sign fix-up.
REQ-022 Signed results: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-023 Divide by zero uses the fast path (DONE the cycle after accept): quotient = all ones, remainder = dividend.
REQ-024 Signed overflow (op_a = -2^(XLEN-1), op_b = -1) uses the fast path: quotient = op_a, remainder = 0.
REQ-025 DONE: resp_valid_o=1 and resp_data_o/resp_waddr_o held stable until resp_ready_i.
REQ-026 On handshake go to IDLE; req_ready_o=1 the following cycle, with no same-cycle back-to-back accept.
REQ-027 busy_o = (state != IDLE) & !(state==DONE & resp_ready_i).
REQ-028 flush_i in any state forces IDLE next cycle; a DONE result not yet handshaken is discarded.
REQ-029 flush_i has priority over resp_ready_i and req_valid_i in the same cycle.
REQ-030 Requests arriving while req_ready_o=0 are ignored; the upstream holds them.
REQ-031 Outside DONE, resp_valid_o=0 and resp_data_o is don't-care; verification checks it only when valid.

Reset
REQ-032 On rst_n low: state=IDLE, counters=0, and all operand/result registers=0, immediately and asynchronously.
REQ-033 After reset: req_ready_o=1, resp_valid_o=0, busy_o=0, resp_data_o=0, resp_waddr_o=0.
REQ-034 Reset mid-operation abandons the operation; no response is ever produced for it.

Structure
REQ-035 The 3-bit MDU op encodings and the state encodings live in the shared define file beside the existing ALU control codes.
REQ-036 The iterative divider (magnitudes, sign fix-up, special-case detection) is one sub-module, ex_mdu_div; the multiplier stays inline in ex_mdu.
REQ-037 No memories and no multi-cycle combinational paths; the product register is 2*XLEN wide.

Verification
REQ-038 MUL 7 x -3, resp_ready_i=1 -> resp_data=0xFFFFFFEB exactly 2 cycles after accept.
REQ-039 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-040 DIV -7 / 2 -> 0xFFFFFFFD and REM -7 / 2 -> 0xFFFFFFFF, each 33 cycles after accept (RADIX_LOG2=1).
REQ-041 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; each valid 1 cycle after accept.
REQ-042 DIV accepted, flush_i pulsed at cycle 10 -> IDLE next cycle, resp_valid never asserts, busy_o=0, a new MUL is accepted normally.
REQ-043 Result held with resp_ready_i=0 for 5 cycles -> data and waddr stable, busy_o=1; handshake completes on the resp_ready_i rise.
